// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: decode-side forwarding, branch resolution, load-use/branch FSM, freeze and stall counter.
// Rev 1.0
`default_nettype none

module hazard_ctrl_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int LOAD_LAT = 1,
  parameter int BR_FLUSH = 1,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branchD,
  input  logic              immediateD,
  input  logic [ADDR_W-1:0] srcAdd1,
  input  logic [ADDR_W-1:0] srcAdd2,
  input  logic [DATA_W-1:0] srcData1,
  input  logic [DATA_W-1:0] srcData2,
  input  logic [ADDR_W-1:0] destAddE,
  input  logic [ADDR_W-1:0] destAddM,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              MemToRegE,
  input  logic              MemToRegM,
  input  logic [DATA_W-1:0] alu_resultE,
  input  logic [DATA_W-1:0] resultM,
  input  logic              mem_ready,
  input  logic              flush_req,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushD,
  output logic              flushE,
  output logic [1:0]        forwardA,
  output logic [1:0]        forwardB,
  output logic              InstBranch,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int MAX_LAT = (LOAD_LAT > BR_FLUSH) ? LOAD_LAT : BR_FLUSH;
  localparam int CTR_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CTR_W-1:0] LD_INIT = CTR_W'(LOAD_LAT - 1);
  localparam logic [CTR_W-1:0] BR_INIT = CTR_W'(BR_FLUSH - 1);
  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LD   = 2'd1;
  localparam logic [1:0] S_BR   = 2'd2;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_E  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  logic [1:0]        state, state_nxt;
  logic [CTR_W-1:0]  cnt, cnt_nxt;

  logic              match_a_e, match_a_m, match_b_e, match_b_m;
  logic [1:0]        fwd_a, fwd_b;
  logic [DATA_W-1:0] op_a, op_b;
  logic              ldhaz, brtake;
  logic              st_f, st_d, st_e, fl_d, fl_e, br_taken;

  // M-stage loads already carry their loaded value in resultM, so M forwarding ignores MemToRegM.
  logic              unused_memtoregm;
  assign unused_memtoregm = MemToRegM;

  function automatic logic addr_match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] d);
    return (a == d) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign match_a_e = addr_match(srcAdd1, destAddE);
  assign match_a_m = addr_match(srcAdd1, destAddM);
  assign match_b_e = addr_match(srcAdd2, destAddE) && !immediateD;
  assign match_b_m = addr_match(srcAdd2, destAddM) && !immediateD;

  always_comb begin
    fwd_a = FWD_RF;
    if (RegWriteE && !MemToRegE && match_a_e)
      fwd_a = FWD_E;
    else if (RegWriteM && match_a_m)
      fwd_a = FWD_M;
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (RegWriteE && !MemToRegE && match_b_e)
      fwd_b = FWD_E;
    else if (RegWriteM && match_b_m)
      fwd_b = FWD_M;
  end

  always_comb begin
    case (fwd_a)
      FWD_E:   op_a = alu_resultE;
      FWD_M:   op_a = resultM;
      default: op_a = srcData1;
    endcase
  end

  always_comb begin
    case (fwd_b)
      FWD_E:   op_b = alu_resultE;
      FWD_M:   op_b = resultM;
      default: op_b = srcData2;
    endcase
  end

  assign ldhaz  = MemToRegE && RegWriteE && (match_a_e || match_b_e);
  assign brtake = branchD && (op_a == op_b) && !ldhaz;

  always_comb begin
    st_f      = 1'b0;
    st_d      = 1'b0;
    st_e      = 1'b0;
    fl_d      = 1'b0;
    fl_e      = 1'b0;
    br_taken  = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!mem_ready) begin
      st_f = 1'b1;
      st_d = 1'b1;
      st_e = 1'b1;
    end else if (flush_req) begin
      fl_d      = 1'b1;
      fl_e      = 1'b1;
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ldhaz) begin
            st_f = 1'b1;
            st_d = 1'b1;
            fl_e = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt = S_LD;
              cnt_nxt   = LD_INIT;
            end
          end else if (brtake) begin
            fl_d     = 1'b1;
            br_taken = 1'b1;
            if (BR_FLUSH > 1) begin
              state_nxt = S_BR;
              cnt_nxt   = BR_INIT;
            end
          end
        end
        S_LD: begin
          st_f    = 1'b1;
          st_d    = 1'b1;
          fl_e    = 1'b1;
          cnt_nxt = cnt - CTR_ONE;
          if (cnt <= CTR_ONE) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end
        end
        S_BR: begin
          fl_d    = 1'b1;
          cnt_nxt = cnt - CTR_ONE;
          if (cnt <= CTR_ONE) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are masked by reset so they fall as soon as reset rises, not at the next edge.
  assign stallF     = st_f & ~reset;
  assign stallD     = st_d & ~reset;
  assign stallE     = st_e & ~reset;
  assign flushD     = fl_d & ~reset;
  assign flushE     = fl_e & ~reset;
  assign InstBranch = br_taken & ~reset;
  assign forwardA   = reset ? FWD_RF : fwd_a;
  assign forwardB   = reset ? FWD_RF : fwd_b;
  assign busy       = (state != S_IDLE) & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (stallF && !(&stall_cycles))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

`default_nettype wire
